// File: rtl/leaf_fifo_bank.sv
// leaf_fifo_bank: 2*L independent first-word-fall-through leaf FIFOs fed by one shared write port
module leaf_fifo_bank #(
    parameter int L     = 8,
    parameter int DEPTH = 4,
    parameter int W     = 128,
    localparam int N    = 2 * L,
    localparam int LW   = $clog2(N),
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wr_valid,
    input  logic [LW-1:0]   i_wr_leaf,
    input  logic [W-1:0]    i_wr_data,
    output logic            o_wr_ready,
    output logic [W*N-1:0]  o_fifo,
    output logic [N-1:0]    o_fifo_empty,
    input  logic [N-1:0]    i_fifo_read,
    output logic [N*CW-1:0] o_occupancy,
    output logic            o_err_underflow
);

    logic [AW-1:0] rd_q [N];
    logic [AW-1:0] wr_q [N];
    logic [CW-1:0] cnt_q [N];
    logic [W-1:0]  mem_q [N][DEPTH];
    logic [N-1:0]  full;
    logic [N-1:0]  push;
    logic [N-1:0]  pop;
    logic          err_q;

    // Per-leaf status and head view; an empty leaf shows the entry it last released
    always_comb begin
        for (int k = 0; k < N; k++) begin
            o_fifo_empty[k]         = cnt_q[k] == '0;
            full[k]                 = cnt_q[k] == CW'(DEPTH);
            o_occupancy[CW*k +: CW] = cnt_q[k];
            o_fifo[W*k +: W]        = mem_q[k][o_fifo_empty[k] ? rd_q[k] - AW'(1) : rd_q[k]];
        end
    end

    assign o_wr_ready      = !full[i_wr_leaf] || i_fifo_read[i_wr_leaf];
    assign o_err_underflow = err_q;

    // Decode accepted writes and effective pops; pops on empty leaves are dropped
    always_comb begin
        for (int k = 0; k < N; k++) begin
            push[k] = i_wr_valid && o_wr_ready && i_wr_leaf == LW'(k);
            pop[k]  = i_fifo_read[k] && !o_fifo_empty[k];
        end
    end

    // Pointer and count bookkeeping; a simultaneous push and pop leaves the count alone
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N; k++) begin
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (push[k]) wr_q[k] <= wr_q[k] + AW'(1);
                if (pop[k]) rd_q[k] <= rd_q[k] + AW'(1);
                cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
            end
        end
    end

    // Entry storage carries no reset; only the pointers decide what is valid
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < N; k++)
            if (push[k]) mem_q[k][wr_q[k]] <= i_wr_data;
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) err_q <= 1'b0;
        else if (|(i_fifo_read & o_fifo_empty)) err_q <= 1'b1;
    end

endmodule

// File: tb/tb_leaf_fifo_bank.sv
// tb_leaf_fifo_bank: directed scoreboard bench for leaf_fifo_bank (L=8, DEPTH=4, W=128)
module tb_leaf_fifo_bank;

    localparam int N  = 16;
    localparam int W  = 128;
    localparam int CW = 3;

    logic            clk;
    logic            rst_n;
    logic            wr_valid;
    logic [3:0]      wr_leaf;
    logic [W-1:0]    wr_data;
    logic            wr_ready;
    logic [W*N-1:0]  fifo;
    logic [N-1:0]    fifo_empty;
    logic [N-1:0]    fifo_read;
    logic [N*CW-1:0] occupancy;
    logic            err_underflow;

    typedef struct {
        int           leaf;
        logic [W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    leaf_fifo_bank #(.L(8), .DEPTH(4), .W(W)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_wr_valid     (wr_valid),
        .i_wr_leaf      (wr_leaf),
        .i_wr_data      (wr_data),
        .o_wr_ready     (wr_ready),
        .o_fifo         (fifo),
        .o_fifo_empty   (fifo_empty),
        .i_fifo_read    (fifo_read),
        .o_occupancy    (occupancy),
        .o_err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every pop the DUT honours must match the oldest expected head
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < N; k++) begin
                if (fifo_read[k] && !fifo_empty[k]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_unexpected leaf %0d: got %h, required no data", k, fifo[W*k +: W]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.leaf != k || fifo[W*k +: W] !== e.data) begin
                            errors++;
                            $display("FAIL pop_head leaf %0d data %h, required leaf %0d data %h", k, fifo[W*k +: W], e.leaf, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int leaf, input logic [W-1:0] d);
        wr_valid = 1'b1;
        wr_leaf  = 4'(leaf);
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop(input int leaf, input logic [W-1:0] d);
        exp_t e;
        e.leaf = leaf;
        e.data = d;
        exp_q.push_back(e);
        fifo_read = N'(1) << leaf;
        step();
        fifo_read = '0;
    endtask

    function automatic logic [W-1:0] occ(input int k);
        return W'(occupancy[CW*k +: CW]);
    endfunction

    function automatic logic [W-1:0] head(input int k);
        return fifo[W*k +: W];
    endfunction

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_leaf   = '0;
        wr_data   = '0;
        fifo_read = '0;
        #12;
        chk("reset_empty", W'(fifo_empty), W'(16'hFFFF));
        chk("reset_occ", W'(occupancy), '0);
        chk("reset_err", W'(err_underflow), '0);
        chk("reset_ready", W'(wr_ready), W'(1));
        rst_n = 1'b1;
        step();

        // single write to leaf 3
        wr(3, W'(32'hA));
        chk("w3_empty", W'(fifo_empty), W'(16'hFFF7));
        chk("w3_head", head(3), W'(32'hA));
        chk("w3_occ", occ(3), W'(1));
        pop(3, W'(32'hA));
        chk("w3_drained", W'(fifo_empty), W'(16'hFFFF));

        // write with valid low is ignored
        wr_valid = 1'b0;
        wr_leaf  = 4'd6;
        wr_data  = W'(32'hDEAD);
        step();
        chk("novalid_occ", occ(6), '0);

        // fill leaf 0 and check back-pressure
        for (int i = 1; i <= 4; i++) wr(0, W'(i));
        chk("full0_occ", occ(0), W'(4));
        wr_leaf = 4'd0;
        #1;
        chk("full0_ready", W'(wr_ready), '0);
        wr_leaf = 4'd1;
        #1;
        chk("leaf1_ready", W'(wr_ready), W'(1));
        for (int i = 1; i <= 4; i++) pop(0, W'(i));
        chk("leaf0_empty", W'(fifo_empty[0]), W'(1));

        // full leaf 5: write and pop in the same cycle
        for (int i = 5; i <= 8; i++) wr(5, W'(i));
        wr_valid  = 1'b1;
        wr_leaf   = 4'd5;
        wr_data   = W'(9);
        fifo_read = N'(1) << 5;
        exp_q.push_back('{5, W'(5)});
        #1;
        chk("full5_ready_pass", W'(wr_ready), W'(1));
        step();
        wr_valid  = 1'b0;
        fifo_read = '0;
        chk("pass5_occ", occ(5), W'(4));
        for (int i = 6; i <= 9; i++) pop(5, W'(i));
        chk("leaf5_empty", W'(fifo_empty[5]), W'(1));
        chk("no_err_yet", W'(err_underflow), '0);

        // empty leaf 2: write and pop together
        wr_valid  = 1'b1;
        wr_leaf   = 4'd2;
        wr_data   = W'(32'h11);
        fifo_read = N'(1) << 2;
        step();
        wr_valid  = 1'b0;
        fifo_read = '0;
        chk("uf2_occ", occ(2), W'(1));
        chk("uf2_head", head(2), W'(32'h11));
        chk("uf2_err", W'(err_underflow), W'(1));
        pop(2, W'(32'h11));
        chk("uf2_err_sticky", W'(err_underflow), W'(1));

        // reset to clear underflow, then leaves 0 and 15 popped together
        rst_n = 1'b0;
        #2;
        chk("rst_clears_err", W'(err_underflow), '0);
        rst_n = 1'b1;
        step();
        wr(0, W'(32'h100));
        wr(15, W'(32'h1500));
        chk("two_occ15", occ(15), W'(1));
        exp_q.push_back('{0, W'(32'h100)});
        exp_q.push_back('{15, W'(32'h1500)});
        fifo_read = 16'h8001;
        step();
        fifo_read = '0;
        chk("two_empty", W'(fifo_empty), W'(16'hFFFF));
        chk("two_noerr", W'(err_underflow), '0);

        // asynchronous reset mid-cycle discards leaf 7
        for (int i = 1; i <= 3; i++) wr(7, W'(32'h70 + i));
        chk("l7_occ", occ(7), W'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_empty7", W'(fifo_empty[7]), W'(1));
        chk("async_occ", W'(occupancy), '0);
        #3;
        rst_n = 1'b1;
        step();
        wr(7, W'(32'h5));
        chk("post_rst_head", head(7), W'(32'h5));
        chk("post_rst_occ", occ(7), W'(1));
        pop(7, W'(32'h5));

        step();
        chk("scoreboard_drained", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
